// File: rtl/digit_assembler_if.sv
// Keypad-side event strobes and the assembled value/live-entry outputs
// of digit_assembler, bundled as one port.
interface digit_assembler_if;
    logic        i_digit_valid;
    logic [3:0]  i_digit;
    logic        i_neg;
    logic        i_back;
    logic        i_clear;
    logic        i_enter;
    logic [39:0] o_live_value;
    logic        o_live_sign;
    logic        o_live_err;
    logic [39:0] o_value;
    logic        o_sign;
    logic        o_valid;
    logic [2:0]  o_count;

    modport master (
        output i_digit_valid, i_digit, i_neg, i_back, i_clear, i_enter,
        input  o_live_value, o_live_sign, o_live_err, o_value, o_sign,
        input  o_valid, o_count
    );

    modport slave (
        input  i_digit_valid, i_digit, i_neg, i_back, i_clear, i_enter,
        output o_live_value, o_live_sign, o_live_err, o_value, o_sign,
        output o_valid, o_count
    );
endinterface

// File: rtl/digit_assembler.sv
// Rebuilds a signed decimal number from keypad digit events. The live
// entry is shown while typing; enter commits it to o_value/o_sign with
// a one-cycle o_valid pulse.
module digit_assembler #(
    parameter int unsigned MAX_DIGITS = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    digit_assembler_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        ERR
    } state_t;

    localparam logic [2:0] LIM_POS = 3'(MAX_DIGITS);
    localparam logic [2:0] LIM_NEG = 3'(MAX_DIGITS - 1);

    state_t      state;
    logic [19:0] mag;
    logic        sign;
    logic [2:0]  count;
    logic [19:0] value;
    logic        value_sign;
    logic        valid;

    logic [19:0] mag_times10_plus_d;
    logic [19:0] mag_div10;
    logic [2:0]  digit_limit;

    // Next-magnitude arithmetic for digit append and backspace.
    always_comb begin
        mag_times10_plus_d = {mag[16:0], 3'b000} + {mag[18:0], 1'b0}
                           + {16'd0, bus.i_digit};
        mag_div10          = mag / 20'd10;
        digit_limit        = sign ? LIM_NEG : LIM_POS;
    end

    // Entry state machine; strobes resolved by priority clear > enter >
    // back > neg > digit, with only the winner acted on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= EMPTY;
            mag        <= '0;
            sign       <= 1'b0;
            count      <= '0;
            value      <= '0;
            value_sign <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bus.i_clear) begin
                state <= EMPTY;
                mag   <= '0;
                sign  <= 1'b0;
                count <= '0;
            end else if (state != ERR) begin
                if (bus.i_enter) begin
                    value      <= mag;
                    value_sign <= sign & (mag != '0);
                    valid      <= 1'b1;
                    state      <= EMPTY;
                    mag        <= '0;
                    sign       <= 1'b0;
                    count      <= '0;
                end else if (bus.i_back) begin
                    if (count != '0) begin
                        mag   <= mag_div10;
                        count <= count - 3'd1;
                        if (count == 3'd1) begin
                            state <= EMPTY;
                        end
                    end
                end else if (bus.i_neg) begin
                    // A positive full-width entry has no room for the minus sign.
                    if (sign || count != LIM_POS) begin
                        sign  <= ~sign;
                        state <= (count != '0 || !sign) ? ENTRY : EMPTY;
                    end
                end else if (bus.i_digit_valid) begin
                    if (bus.i_digit > 4'd9) begin
                        state <= ERR;
                    end else if (bus.i_digit == 4'd0 && mag == '0) begin
                        // Leading zero: nothing to record.
                    end else if (count < digit_limit) begin
                        mag   <= mag_times10_plus_d;
                        count <= count + 3'd1;
                        state <= ENTRY;
                    end
                end
            end
        end
    end

    assign bus.o_live_value = {20'd0, mag};
    assign bus.o_live_sign  = sign;
    assign bus.o_live_err   = (state == ERR);
    assign bus.o_value      = {20'd0, value};
    assign bus.o_sign       = value_sign;
    assign bus.o_valid      = valid;
    assign bus.o_count      = count;

endmodule

// File: tb/tb_digit_assembler.sv
// Table-driven bench for digit_assembler with a scoreboard queue of
// expected outputs, plus hand-written async-reset sequences.
module tb_digit_assembler;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] DV   = 5'b00001;
    localparam logic [4:0] NG   = 5'b00010;
    localparam logic [4:0] BK   = 5'b00100;
    localparam logic [4:0] EN   = 5'b01000;
    localparam logic [4:0] CL   = 5'b10000;

    typedef struct {
        logic [4:0] ev;
        logic [3:0] d;
        int         lv;
        logic       ls;
        logic       le;
        int         cnt;
        logic       vld;
        int         val;
        logic       sg;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    digit_assembler_if bus();

    digit_assembler #(.MAX_DIGITS(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] ev, input int d, input int lv,
                                input logic ls, input logic le, input int cnt,
                                input logic vld, input int val, input logic sg);
        vec_t v;
        v.ev = ev; v.d = 4'(d); v.lv = lv; v.ls = ls; v.le = le;
        v.cnt = cnt; v.vld = vld; v.val = val; v.sg = sg;
        return v;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " live_value"}, bus.o_live_value, 40'd0);
        check({tag, " live_sign"}, {39'd0, bus.o_live_sign}, 40'd0);
        check({tag, " live_err"}, {39'd0, bus.o_live_err}, 40'd0);
        check({tag, " value"}, bus.o_value, 40'd0);
        check({tag, " sign"}, {39'd0, bus.o_sign}, 40'd0);
        check({tag, " valid"}, {39'd0, bus.o_valid}, 40'd0);
        check({tag, " count"}, {37'd0, bus.o_count}, 40'd0);
    endtask

    task automatic idle_inputs();
        bus.i_digit_valid = 1'b0;
        bus.i_digit       = 4'd0;
        bus.i_neg         = 1'b0;
        bus.i_back        = 1'b0;
        bus.i_clear       = 1'b0;
        bus.i_enter       = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        string t;
        @(negedge clk);
        bus.i_digit_valid = v.ev[0];
        bus.i_neg         = v.ev[1];
        bus.i_back        = v.ev[2];
        bus.i_enter       = v.ev[3];
        bus.i_clear       = v.ev[4];
        bus.i_digit       = v.d;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        idle_inputs();
        e = exp_q.pop_front();
        t = $sformatf("v%0d", idx);
        check({t, " live_value"}, bus.o_live_value, 40'(e.lv));
        check({t, " live_sign"}, {39'd0, bus.o_live_sign}, {39'd0, e.ls});
        check({t, " live_err"}, {39'd0, bus.o_live_err}, {39'd0, e.le});
        check({t, " count"}, {37'd0, bus.o_count}, 40'(e.cnt));
        check({t, " valid"}, {39'd0, bus.o_valid}, {39'd0, e.vld});
        check({t, " value"}, bus.o_value, 40'(e.val));
        check({t, " sign"}, {39'd0, bus.o_sign}, {39'd0, e.sg});
    endtask

    initial begin
        idle_inputs();

        // Entry and commit
        vecs.push_back(mk(DV, 1, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(DV, 2, 12, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(DV, 3, 123, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(DV, 4, 1234, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(DV, 5, 12345, 0, 0, 5, 0, 0, 0));
        vecs.push_back(mk(DV, 6, 123456, 0, 0, 6, 0, 0, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 123456, 0));
        vecs.push_back(mk(NONE, 0, 0, 0, 0, 0, 0, 123456, 0));
        // Leading zeros and positive digit limit
        vecs.push_back(mk(DV, 0, 0, 0, 0, 0, 0, 123456, 0));
        vecs.push_back(mk(DV, 0, 0, 0, 0, 0, 0, 123456, 0));
        vecs.push_back(mk(DV, 7, 7, 0, 0, 1, 0, 123456, 0));
        vecs.push_back(mk(DV, 1, 71, 0, 0, 2, 0, 123456, 0));
        vecs.push_back(mk(DV, 2, 712, 0, 0, 3, 0, 123456, 0));
        vecs.push_back(mk(DV, 3, 7123, 0, 0, 4, 0, 123456, 0));
        vecs.push_back(mk(DV, 4, 71234, 0, 0, 5, 0, 123456, 0));
        vecs.push_back(mk(DV, 5, 712345, 0, 0, 6, 0, 123456, 0));
        vecs.push_back(mk(DV, 9, 712345, 0, 0, 6, 0, 123456, 0));
        vecs.push_back(mk(NG, 0, 712345, 0, 0, 6, 0, 123456, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 712345, 0));
        // Negative digit limit
        vecs.push_back(mk(NG, 0, 0, 1, 0, 0, 0, 712345, 0));
        vecs.push_back(mk(DV, 9, 9, 1, 0, 1, 0, 712345, 0));
        vecs.push_back(mk(DV, 8, 98, 1, 0, 2, 0, 712345, 0));
        vecs.push_back(mk(DV, 7, 987, 1, 0, 3, 0, 712345, 0));
        vecs.push_back(mk(DV, 6, 9876, 1, 0, 4, 0, 712345, 0));
        vecs.push_back(mk(DV, 5, 98765, 1, 0, 5, 0, 712345, 0));
        vecs.push_back(mk(DV, 4, 98765, 1, 0, 5, 0, 712345, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 98765, 1));
        // Backspace
        vecs.push_back(mk(DV, 4, 4, 0, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(DV, 2, 42, 0, 0, 2, 0, 98765, 1));
        vecs.push_back(mk(DV, 0, 420, 0, 0, 3, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 42, 0, 0, 2, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 4, 0, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 0, 0, 0, 0, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 0, 0, 0, 0, 0, 98765, 1));
        // Backspace to empty keeps a negative sign
        vecs.push_back(mk(NG, 0, 0, 1, 0, 0, 0, 98765, 1));
        vecs.push_back(mk(DV, 3, 3, 1, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 0, 1, 0, 0, 0, 98765, 1));
        vecs.push_back(mk(CL, 0, 0, 0, 0, 0, 0, 98765, 1));
        // Error path: only clear has effect
        vecs.push_back(mk(DV, 3, 3, 0, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(DV, 12, 3, 0, 1, 1, 0, 98765, 1));
        vecs.push_back(mk(EN, 0, 3, 0, 1, 1, 0, 98765, 1));
        vecs.push_back(mk(DV, 5, 3, 0, 1, 1, 0, 98765, 1));
        vecs.push_back(mk(NG, 0, 3, 0, 1, 1, 0, 98765, 1));
        vecs.push_back(mk(BK, 0, 3, 0, 1, 1, 0, 98765, 1));
        vecs.push_back(mk(CL, 0, 0, 0, 0, 0, 0, 98765, 1));
        vecs.push_back(mk(DV, 15, 0, 0, 1, 0, 0, 98765, 1));
        vecs.push_back(mk(CL, 0, 0, 0, 0, 0, 0, 98765, 1));
        // Priority: clear beats enter
        vecs.push_back(mk(DV, 5, 5, 0, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(DV, 5, 55, 0, 0, 2, 0, 98765, 1));
        vecs.push_back(mk(CL | EN, 0, 0, 0, 0, 0, 0, 98765, 1));
        // Priority: enter beats back, back beats neg, neg beats digit
        vecs.push_back(mk(DV, 1, 1, 0, 0, 1, 0, 98765, 1));
        vecs.push_back(mk(DV, 2, 12, 0, 0, 2, 0, 98765, 1));
        vecs.push_back(mk(EN | BK, 0, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(DV, 3, 3, 0, 0, 1, 0, 12, 0));
        vecs.push_back(mk(BK | NG, 0, 0, 0, 0, 0, 0, 12, 0));
        vecs.push_back(mk(NG | DV, 7, 0, 1, 0, 0, 0, 12, 0));
        vecs.push_back(mk(CL, 0, 0, 0, 0, 0, 0, 12, 0));
        // Enter on empty, back-to-back enters, negative zero commits positive
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(DV, 8, 8, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 8, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(NG, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 0, 0));
        // Set up a committed value and partial entry for the reset test
        vecs.push_back(mk(DV, 6, 6, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(EN, 0, 0, 0, 0, 0, 1, 6, 0));
        vecs.push_back(mk(DV, 7, 7, 0, 0, 1, 0, 6, 0));
        vecs.push_back(mk(DV, 7, 77, 0, 0, 2, 0, 6, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset mid-entry clears outputs before the next clock edge
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("after_reset");

        // A pending enter lost to reset produces no pulse
        @(negedge clk);
        bus.i_digit_valid = 1'b1;
        bus.i_digit       = 4'd4;
        @(negedge clk);
        idle_inputs();
        bus.i_enter = 1'b1;
        #2;
        rst = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_over_enter");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_assembler.md
# digit_assembler

Builds a signed decimal number one digit at a time from keypad entry events and presents it as the binary value, sign and error flag that `digit_separator` consumes. It is the inverse of the display path:
- `digit_separator` splits a value into six display digits.
- `digit_assembler` takes digits and rebuilds the value.

It sits between the keypad decoder and the value/display mux. The live entry drives the display while typing, and the committed value is handed to downstream logic on enter.

## Interface
- MAX_DIGITS, 6, maximum magnitude digits (one per display position).
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_digit_valid  input  1  one-cycle strobe: i_digit holds a new key.
- i_digit  input  4  digit code; 0–9 are legal, 10–15 are illegal.
- i_neg  input  1  one-cycle strobe: toggle entry sign.
- i_back  input  1  one-cycle strobe: delete the least significant digit.
- i_clear  input  1  one-cycle strobe: abandon the entry, clear error.
- i_enter  input  1  one-cycle strobe: commit the entry.
- o_live_value  output  40  current entry magnitude (binary, zero-extended).
- o_live_sign  output  1  current entry sign (1 = negative).
- o_live_err  output  1  entry is in error state.
- o_value  output  40  last committed magnitude.
- o_sign  output  1  last committed sign.
- o_valid  output  1  one-cycle pulse; o_value/o_sign were just updated.
- o_count  output  3  number of significant digits in the entry, 0..6.

## Operation
- States:
  - EMPTY: magnitude 0, count 0.
  - ENTRY: count ≥ 1, or the sign has been set.
  - ERR
- Event priority when several strobes are high in one cycle: i_clear > i_enter > i_back > i_neg > i_digit_valid. Only the highest is acted on; the others are dropped.
- Digit (legal, d ≤ 9):
  - new = old*10 + d, computed as (old<<3)+(old<<1)+d.
  - Count increments, except that d=0 with magnitude 0 is a leading zero: no change, stays EMPTY.
  - Digit limit: MAX_DIGITS when positive, MAX_DIGITS−1 when negative (the top display position shows the minus sign). A digit at the limit is ignored silently.
- Digit (illegal, d ≥ 10): go to ERR; o_live_err=1; magnitude, sign and count are frozen.
- i_neg toggles the sign in EMPTY or ENTRY. It is ignored when the sign is positive and count == MAX_DIGITS (the result would not fit on the display).
- i_back:
  - new = old/10, count−1.
  - When count reaches 0: go to EMPTY with the sign retained.
  - In EMPTY: no effect.
- i_enter in EMPTY or ENTRY:
  - o_value ← magnitude.
  - o_sign ← sign, forced to 0 when the magnitude is 0.
  - o_valid pulses.
  - The entry resets to EMPTY with positive sign.
- i_enter in ERR: ignored; o_valid stays 0.
- i_clear in any state: go to EMPTY, positive sign, err cleared. o_value and o_sign are untouched.
- In ERR, only i_clear (or reset) has effect.
- Arithmetic:
  - Internal magnitude is 20 bits (999999 < 2^20), zero-extended to 40 bits on output.
  - The /10 is combinational.
  - Overflow is impossible by the digit limit.

## Timing
- Reset (asynchronous, immediate): every output is 0, state is EMPTY.
- All outputs are registered. An event sampled at rising edge N appears on the outputs after edge N and is stable for cycle N+1.
- o_valid is high for exactly the one cycle after the enter edge. Back-to-back enters on consecutive cycles give two pulses, the second with value 0.
- A strobe held high for k cycles counts as k events; the keypad decoder guarantees single-cycle strobes.
- Reset asserted mid-entry discards the partial entry and committed value; no o_valid is produced.

## Test plan
- Entry and commit:
  - Stimulus: reset; digits 1,2,3,4,5,6; enter.
  - Required: o_live_value steps 1, 12, 123, 1234, 12345, 123456, o_count 1..6; o_value=123456, o_sign=0; one-cycle o_valid; live entry back to 0.
- Digit limit and leading zeros:
  - Stimulus: digits 0,0,7 → o_live_value=7, o_count=1; then 1,2,3,4,5,9.
  - Required: 9 ignored, value 712345; i_neg ignored with sign staying 0.
- Negative limit:
  - Stimulus: i_neg, then digits 9,8,7,6,5,4; enter.
  - Required: 4 ignored; o_value=98765, o_sign=1.
- Backspace:
  - Stimulus: digits 4,2,0; back → 42; back, back → EMPTY, o_count=0; back again.
  - Required: no change on the final back.
- Error path:
  - Stimulus: digit 3, then i_digit=12 → o_live_err=1, value 3 frozen; enter gives no o_valid; digit 5 ignored.
  - Required: i_clear → err=0, value 0, with o_value unchanged from the prior commit.
- Priority and reset:
  - Stimulus: i_clear+i_enter in the same cycle with entry 55.
  - Required: clear wins, no o_valid. Then async i_rst mid-entry: all outputs go to 0 immediately, before the next clock edge.
